// File: rtl/fpu_types_pkg.sv
// Shared Zhinx FPU encoding definitions: opcodes, funct5 values, request layout
// and the legality rule used by both the decode and encode stages.
package fpu_types_pkg;

  localparam logic [6:0] OPCODE_OPFP   = 7'b1010011;
  localparam logic [6:0] OPCODE_FMADD  = 7'b1000011;
  localparam logic [6:0] OPCODE_FMSUB  = 7'b1000111;
  localparam logic [6:0] OPCODE_FNMADD = 7'b1001111;
  localparam logic [6:0] OPCODE_FNMSUB = 7'b1001011;

  localparam logic [1:0] FMT_H = 2'b10;

  typedef enum logic [2:0] {
    SEL_OPFP   = 3'd0,
    SEL_FMADD  = 3'd1,
    SEL_FMSUB  = 3'd2,
    SEL_FNMADD = 3'd3,
    SEL_FNMSUB = 3'd4
  } select_e;

  typedef enum logic [4:0] {
    F5_FADD     = 5'b00000,
    F5_FSUB     = 5'b00001,
    F5_FMUL     = 5'b00010,
    F5_FDIV     = 5'b00011,
    F5_FSGNJ    = 5'b00100,
    F5_FMINMAX  = 5'b00101,
    F5_FSQRT    = 5'b01011,
    F5_FCMP     = 5'b10100,
    F5_FCVT_W_H = 5'b11000,
    F5_FCVT_H_W = 5'b11010,
    F5_FCLASS   = 5'b11100
  } funct5_e;

  typedef struct packed {
    logic [2:0] select;
    logic [4:0] funct5;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rs3;
    logic [2:0] rm;
  } rv32zhinx_req_t;

  // rm doubles as funct3 for sign-inject, compare, min/max and classify.
  function automatic logic is_legal(input logic [2:0] select,
                                    input logic [4:0] funct5,
                                    input logic [2:0] rm);
    logic ok;
    ok = (select <= 3'd4) && (rm != 3'b101) && (rm != 3'b110);
    if (select == SEL_OPFP) begin
      case (funct5)
        F5_FADD, F5_FSUB, F5_FMUL, F5_FDIV,
        F5_FSQRT, F5_FCVT_W_H, F5_FCVT_H_W: ;
        F5_FSGNJ, F5_FCMP: if (rm > 3'b010) ok = 1'b0;
        F5_FMINMAX:        if (rm > 3'b001) ok = 1'b0;
        F5_FCLASS:         if (rm != 3'b001) ok = 1'b0;
        default:           ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/rv32zhinx_insn_fifo.sv
// First-word fall-through FIFO for encoded instruction words. While empty the
// output holds the most recently popped word (zero after reset).
module rv32zhinx_insn_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] hold_q;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? hold_q : mem[rd_ptr];

  // NOTE: storage has no reset; an entry is only visible once written, and
  // hold_q covers the empty case so the output is never X.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        hold_q <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rv32zhinx_encode.sv
// Zhinx instruction encoder: checks decoded FPU requests, assembles the RV32
// word and queues it for the core; rejected requests pulse err.
module rv32zhinx_encode
  import fpu_types_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_select,
  input  logic [4:0]       req_funct5,
  input  logic [4:0]       req_rd,
  input  logic [4:0]       req_rs1,
  input  logic [4:0]       req_rs2,
  input  logic [4:0]       req_rs3,
  input  logic [2:0]       req_rm,
  output logic             insn_valid,
  input  logic             insn_ready,
  output logic [31:0]      insn,
  output logic             err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] rej_count
);

  rv32zhinx_req_t req;
  logic           legal;
  logic           accept;
  logic           push;
  logic           fifo_full;
  logic           fifo_empty;
  logic [6:0]     opcode;
  logic [4:0]     hi5;
  logic [4:0]     rs2_eff;
  logic [31:0]    word;

  assign req = '{select: req_select, funct5: req_funct5, rd: req_rd,
                 rs1: req_rs1, rs2: req_rs2, rs3: req_rs3, rm: req_rm};

  assign legal      = is_legal(req.select, req.funct5, req.rm);
  assign req_ready  = !fifo_full;
  assign accept     = req_valid && req_ready;
  assign push       = accept && legal;
  assign insn_valid = !fifo_empty;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    opcode  = OPCODE_OPFP;
    hi5     = req.rs3;
    rs2_eff = req.rs2;
    case (req.select)
      SEL_FMADD:  opcode = OPCODE_FMADD;
      SEL_FMSUB:  opcode = OPCODE_FMSUB;
      SEL_FNMADD: opcode = OPCODE_FNMADD;
      SEL_FNMSUB: opcode = OPCODE_FNMSUB;
      default:    opcode = OPCODE_OPFP;
    endcase
    if (req.select == SEL_OPFP) begin
      hi5 = req.funct5;
      // Unary ops carry no second source; rs2 field must read zero.
      if (req.funct5 == F5_FSQRT || req.funct5 == F5_FCLASS) rs2_eff = '0;
    end
    word = {hi5, FMT_H, rs2_eff, req.rs1, req.rm, req.rd, opcode};
  end

  rv32zhinx_insn_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (insn_ready),
    .wdata (word),
    .rdata (insn),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // NOTE: state registers use non-blocking assignments so every reader sees
  // the pre-edge value regardless of block ordering.
  always_ff @(posedge CLK) begin
    if (RST) begin
      err       <= 1'b0;
      enc_count <= '0;
      rej_count <= '0;
    end else begin
      err <= accept && !legal;
      if (push && enc_count != '1) enc_count <= enc_count + CNT_W'(1);
      if (accept && !legal && rej_count != '1) rej_count <= rej_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rv32zhinx_encode.sv
// Scoreboard bench for rv32zhinx_encode: a driver pushes modelled words, a
// monitor pops and compares them (plus a loopback decode) as the DUT emits.
module tb_rv32zhinx_encode;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [2:0]       req_select = '0;
  logic [4:0]       req_funct5 = '0;
  logic [4:0]       req_rd = '0;
  logic [4:0]       req_rs1 = '0;
  logic [4:0]       req_rs2 = '0;
  logic [4:0]       req_rs3 = '0;
  logic [2:0]       req_rm = '0;
  logic             insn_valid;
  logic             insn_ready = 1'b0;
  logic [31:0]      insn;
  logic             err;
  logic [CNT_W-1:0] enc_count;
  logic [CNT_W-1:0] rej_count;

  rv32zhinx_encode #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK        (clk),
    .RST        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_select (req_select),
    .req_funct5 (req_funct5),
    .req_rd     (req_rd),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_rs3    (req_rs3),
    .req_rm     (req_rm),
    .insn_valid (insn_valid),
    .insn_ready (insn_ready),
    .insn       (insn),
    .err        (err),
    .enc_count  (enc_count),
    .rej_count  (rej_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    int          sel;
    int          f5;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   m_enc = 0;
  int   m_rej = 0;
  bit   err_exp = 0;
  bit   rdy_s;
  bit   rnd_ready = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding built from field weights and lookup tables.
  function automatic void model(input int sel, input int f5, input int rd, input int rs1,
                                input int rs2, input int rs3, input int rm,
                                output bit legal, output logic [31:0] word);
    int legal_f5[11] = '{0, 1, 2, 3, 11, 4, 5, 20, 24, 26, 28};
    int op_tab[5] = '{'h53, 'h43, 'h47, 'h4F, 'h4B};
    bit f5_ok = 0;
    int max_rm = 7;
    int top;
    int r2;
    longint w;
    foreach (legal_f5[i]) if (legal_f5[i] == f5) f5_ok = 1;
    if (f5 == 4 || f5 == 20) max_rm = 2;
    if (f5 == 5) max_rm = 1;
    legal = (sel <= 4) && (rm != 5) && (rm != 6) &&
            (sel != 0 || (f5_ok && rm <= max_rm && (f5 != 28 || rm == 1)));
    top = (sel == 0) ? f5 : rs3;
    r2  = (sel == 0 && (f5 == 11 || f5 == 28)) ? 0 : rs2;
    w = longint'(top) * 134217728 + 2 * 33554432 + longint'(r2) * 1048576 +
        rs1 * 32768 + rm * 4096 + rd * 128 + ((sel <= 4) ? op_tab[sel] : 'h53);
    word = w[31:0];
  endfunction

  // One clock of driving: checks registered outputs, then records the accept.
  task automatic step(output bit acc);
    bit          legal;
    logic [31:0] w;
    exp_t        e;
    @(negedge clk);
    check("err", 32'(err), 32'(err_exp));
    check("enc_count", 32'(enc_count), m_enc);
    check("rej_count", 32'(rej_count), m_rej);
    rdy_s   = req_ready;
    acc     = req_valid && req_ready;
    err_exp = 0;
    if (acc) begin
      model(req_select, req_funct5, req_rd, req_rs1, req_rs2, req_rs3, req_rm, legal, w);
      if (legal) begin
        e.word = w; e.sel = req_select; e.f5 = req_funct5;
        exp_q.push_back(e);
        if (m_enc < 65535) m_enc++;
      end else begin
        if (m_rej < 65535) m_rej++;
        err_exp = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [2:0] sel, input logic [4:0] f5, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rs3,
                      input logic [2:0] rm);
    bit acc = 0;
    req_select = sel; req_funct5 = f5; req_rd = rd; req_rs1 = rs1;
    req_rs2 = rs2; req_rs3 = rs3; req_rm = rm; req_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (rnd_ready) insn_ready = 1'($urandom_range(0, 1));
      step(acc);
      if (acc) break;
    end
    if (!acc) begin
      n_checks++; n_err++;
      $display("FAIL accept_timeout: got no accept expected accept within 64 cycles");
    end
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    req_valid = 1'b0;
    repeat (n) step(acc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    m_enc = 0; m_rej = 0; err_exp = 0;
    #3;
    check("rst_insn_valid", 32'(insn_valid), 0);
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_err", 32'(err), 0);
    check("rst_enc_count", 32'(enc_count), 0);
    check("rst_rej_count", 32'(rej_count), 0);
    check("rst_insn", insn, 32'h0);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  initial begin
    bit          prev_stall = 0;
    logic [31:0] prev_word = '0;
    exp_t        e;
    int          dsel;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
        continue;
      end
      if (prev_stall) begin
        check("stall_valid", 32'(insn_valid), 1);
        check("stall_insn", insn, prev_word);
      end
      if (insn_valid && insn_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL unexpected_word: got %h expected no word", insn);
        end else begin
          e = exp_q.pop_front();
          check("insn", insn, e.word);
          case (insn[6:0])
            7'h53:   dsel = 0;
            7'h43:   dsel = 1;
            7'h47:   dsel = 2;
            7'h4F:   dsel = 3;
            7'h4B:   dsel = 4;
            default: dsel = -1;
          endcase
          check("loop_select", dsel, e.sel);
          if (e.sel == 0) check("loop_funct5", 32'(insn[31:27]), e.f5);
        end
      end
      prev_stall = insn_valid && !insn_ready;
      prev_word  = insn;
    end
  end

  initial begin
    bit acc;
    int f5_pool[11] = '{0, 1, 2, 3, 11, 4, 5, 20, 24, 26, 28};

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single FADD and FMADD with the consumer stalled to inspect the head word.
    insn_ready = 1'b0;
    send(3'd0, 5'b00000, 5'd1, 5'd2, 5'd3, 5'd0, 3'b000);
    #3;
    check("fadd_valid", 32'(insn_valid), 1);
    check("fadd_insn", insn, 32'h0431_00D3);
    check("fadd_enc_count", 32'(enc_count), 1);
    insn_ready = 1'b1;
    idle(1);
    insn_ready = 1'b0;
    send(3'd1, 5'b00000, 5'd1, 5'd2, 5'd3, 5'd4, 3'b111);
    #3;
    check("fmadd_insn", insn, 32'h2431_70C3);
    insn_ready = 1'b1;
    idle(1);

    // Back-to-back illegal requests.
    send(3'd5, 5'b00000, 5'd1, 5'd2, 5'd3, 5'd4, 3'b000);
    send(3'd0, 5'b00000, 5'd1, 5'd2, 5'd3, 5'd4, 3'b101);
    send(3'd0, 5'b01111, 5'd1, 5'd2, 5'd3, 5'd4, 3'b000);
    #3;
    check("illegal_err", 32'(err), 1);
    check("illegal_no_word", 32'(insn_valid), 0);
    check("illegal_rej_count", 32'(rej_count), 3);
    idle(2);

    // Fill to full, then release the consumer.
    insn_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(3'd0, 5'b00010, 5'(i), 5'(i + 1), 5'(i + 2), 5'd0, 3'b001);
    #3;
    check("full_req_ready", 32'(req_ready), 0);
    req_select = 3'd2; req_funct5 = 5'd0; req_rd = 5'd9; req_rs1 = 5'd10;
    req_rs2 = 5'd11; req_rs3 = 5'd12; req_rm = 3'b100; req_valid = 1'b1;
    step(acc);
    check("full_no_accept", 32'(acc), 0);
    insn_ready = 1'b1;
    step(acc);
    check("pop_ready_still_low", 32'(rdy_s), 0);
    check("pop_no_push", 32'(acc), 0);
    step(acc);
    check("ready_after_pop", 32'(acc), 1);
    req_valid = 1'b0;
    send(3'd3, 5'd0, 5'd20, 5'd21, 5'd22, 5'd23, 3'b010);
    idle(DEPTH + 2);

    // Reset with three words queued.
    insn_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(3'd4, 5'd0, 5'(i + 5), 5'd6, 5'd7, 5'd8, 3'b011);
    do_reset();
    insn_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("no_stale_word", 32'(insn_valid), 0);
    end

    // Randomised mix of legal and illegal requests with random back-pressure.
    rnd_ready = 1;
    for (int n = 0; n < 300; n++) begin
      logic [2:0] sel;
      logic [4:0] f5;
      sel = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      f5  = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31))
                                        : 5'(f5_pool[$urandom_range(0, 10)]);
      send(sel, f5, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom));
      if ($urandom_range(0, 3) == 0) idle(1);
    end

    rnd_ready = 0;
    insn_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    check("drain_empty", exp_q.size(), 0);
    idle(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
